// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide
// sequencer.
//   XLEN       - operand/result width, also the iteration count
//   CNT_W      - iteration counter width
//   OP_*       - funct3 encodings of the eight M-extension operations
//   state_t    - sequencer FSM states
//   op_a_signed / op_b_signed - operand signedness per operation
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic op_a_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM:  return 1'b1;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU:  return 1'b0;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: datapath for the iterative multiply/divide.
//   clk, rst       - clock, asynchronous active-high reset
//   load           - capture operand magnitudes, op and sign flags
//   step           - perform one shift-add / restoring-divide iteration
//   fix            - apply sign correction to the datapath registers
//   op             - funct3 of the operation being loaded
//   a_mag, b_mag   - unsigned magnitudes of rs1/rs2
//   neg_q, neg_r   - negate product/quotient, negate remainder
//   res            - sign-corrected, op-selected result (valid in FIX)
module muldiv_iter_core
    import muldiv_pkg::*;
#(
    parameter int unsigned W = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic         fix,
    input  logic [2:0]   op,
    input  logic [W-1:0] a_mag,
    input  logic [W-1:0] b_mag,
    input  logic         neg_q,
    input  logic         neg_r,
    output logic [W-1:0] res
);

    // prod holds {hi, multiplier} for multiply; its low half holds the
    // dividend shifting out / quotient shifting in for divide.
    logic [2*W-1:0] prod;
    logic [W-1:0]   rem;
    logic [W-1:0]   dreg;
    logic [2:0]     op_q;
    logic           neg_q_q;
    logic           neg_r_q;

    logic [W:0]     mul_sum;
    logic [W:0]     shifted;
    logic [W:0]     trial;
    logic           q_bit;
    logic [W-1:0]   q_fix;
    logic [W-1:0]   r_fix;
    logic [2*W-1:0] p_fix;

    always_comb begin
        mul_sum = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, dreg} : '0);
        // The shifted partial remainder is W+1 bits; its borrow against the
        // divisor decides the quotient bit.
        shifted = {rem, prod[W-1]};
        trial   = shifted - {1'b0, dreg};
        q_bit   = ~trial[W];
        q_fix   = neg_q_q ? -prod[W-1:0] : prod[W-1:0];
        r_fix   = neg_r_q ? -rem : rem;
        p_fix   = neg_q_q ? -prod : prod;
        if (op_q[2]) begin
            res = op_q[1] ? r_fix : q_fix;
        end else if (op_q == OP_MUL) begin
            res = p_fix[W-1:0];
        end else begin
            res = p_fix[2*W-1:W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod    <= '0;
            rem     <= '0;
            dreg    <= '0;
            op_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (load) begin
            prod    <= {{W{1'b0}}, a_mag};
            rem     <= '0;
            dreg    <= b_mag;
            op_q    <= op;
            neg_q_q <= neg_q;
            neg_r_q <= neg_r;
        end else if (step) begin
            if (op_q[2]) begin
                prod[W-1:0] <= {prod[W-2:0], q_bit};
                rem         <= q_bit ? trial[W-1:0] : shifted[W-1:0];
            end else begin
                prod <= {mul_sum, prod[W-1:1]};
            end
        end else if (fix) begin
            if (op_q[2]) begin
                prod[W-1:0] <= q_fix;
                rem         <= r_fix;
            end else begin
                prod <= p_fix;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit for the EX stage.
//   clk, rst  - clock, asynchronous active-high reset
//   start     - issue request (sampled only in IDLE)
//   op        - funct3 operation select
//   a, b      - rs1 / rs2 operands
//   flush     - abort any in-flight operation
//   busy      - high in CALC and FIX
//   stall     - pipeline stall request (combinational)
//   done      - one-cycle result-valid pulse
//   result    - registered result, held until the next completion
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              load, step, fix, result_we;
    logic [XLEN-1:0]   result_n, core_res;
    logic [XLEN-1:0]   a_mag, b_mag, short_res;
    logic              sign_a, sign_b, short_path;

    always_comb begin
        sign_a     = op_a_signed(op) & a[XLEN-1];
        sign_b     = op_b_signed(op) & b[XLEN-1];
        a_mag      = sign_a ? -a : a;
        b_mag      = sign_b ? -b : b;
        short_path = 1'b0;
        short_res  = a;
        if (op[2]) begin
            if (b == '0) begin
                short_path = 1'b1;
                short_res  = op[1] ? a : '1;
            end else if (op_b_signed(op) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
                short_path = 1'b1;
                short_res  = op[1] ? '0 : a;
            end
        end
    end

    muldiv_iter_core #(
        .W(XLEN)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .step  (step),
        .fix   (fix),
        .op    (op),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .neg_q (sign_a ^ sign_b),
        .neg_r (sign_a),
        .res   (core_res)
    );

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        step      = 1'b0;
        fix       = 1'b0;
        result_we = 1'b0;
        result_n  = core_res;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    if (short_path) begin
                        result_n  = short_res;
                        result_we = 1'b1;
                        state_n   = DONE;
                    end else begin
                        load    = 1'b1;
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CNT_W'(XLEN - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                fix       = 1'b1;
                result_we = 1'b1;
                state_n   = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Flush overrides everything: no result update, straight to IDLE.
        if (flush) begin
            state_n   = IDLE;
            load      = 1'b0;
            step      = 1'b0;
            fix       = 1'b0;
            result_we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (result_we) begin
                result <= result_n;
            end
        end
    end

    assign busy  = (state == CALC) || (state == FIX);
    assign done  = (state == DONE);
    assign stall = (start && (state == IDLE) && !flush) || busy;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide sequencer in the EX stage, beside the single-cycle ALU. It accepts one M-extension operation at a time, computes it one bit per cycle over XLEN cycles, and holds the pipeline stall until the result is valid. The result then goes to the EX result mux in place of the ALU output. Divide-by-zero and signed overflow complete on a short path with RISC-V-defined results.

## Interface
- XLEN, 32, operand/result width; iteration count = XLEN
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  issue request, valid M-op in EX; sampled only in IDLE
- op  in  3  funct3 encoding (see Operation)
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- flush  in  1  abort in-flight op (branch/trap flush)
- busy  out  1  high in CALC and FIX
- stall  out  1  combinational: (start & state==IDLE & ~flush) | busy
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result, held until next accepted start

## Operation
- op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States:
  - IDLE: accept start, capture a, b and op.
  - CALC: XLEN iterations, counter 0..XLEN-1.
  - FIX: sign correction and result selection.
  - DONE: done=1 for one cycle, then IDLE.
- Accept:
  - Latch the sign flags. a is signed for MULH, MULHSU, DIV, REM. b is signed for MULH, DIV, REM.
  - Convert each signed operand to its magnitude (two's complement negate if the MSB is set).
- Multiply:
  - 2·XLEN product register.
  - Shift-add: each cycle, add the multiplicand if the multiplier LSB is 1, then shift right.
  - FIX negates the 2·XLEN product if sign_a^sign_b.
  - MUL selects the low XLEN bits; the other multiply ops select the high XLEN bits.
- Divide:
  - Restoring division, one quotient bit per cycle, XLEN+1-bit partial remainder.
  - FIX negates the quotient if sign_a^sign_b.
  - FIX negates the remainder if sign_a (the remainder takes the dividend's sign).
- Short path (IDLE → DONE directly, no CALC/FIX):
  - b==0: DIV/DIVU → all-ones; REM/REMU → a.
  - DIV/REM with a==0x8000_0000 and b==all-ones: DIV → 0x8000_0000; REM → 0.
- start while busy or in DONE: ignored; the issuer keeps it asserted while stall is high.
- flush:
  - Any state → IDLE on the next edge.
  - No done is issued; result is unchanged.
  - flush with start in IDLE: flush wins and the op is not accepted.
- Arithmetic is modulo 2^XLEN / 2^(2·XLEN); no exceptions are raised.

## Timing
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0. stall=0 while start=0.
- Start accepted at edge E0; let N = XLEN.
  - CALC: edges E1..EN.
  - FIX: edge E(N+1).
  - done high in the cycle after edge E(N+2).
  - Total latency N+2 cycles (34 for XLEN=32).
- Short path: done high in the cycle after E1 (latency 1).
- stall:
  - High from the issue cycle through the last FIX cycle.
  - Low in the DONE cycle, so EX captures result the same cycle done=1.
- Back-to-back: a new start is accepted in the cycle after DONE (IDLE). Minimum issue spacing is N+3 cycles.
- rst mid-operation: immediate return to reset values; no done.

## Structure
- muldiv_pkg:
  - op encodings (localparams for the 8 funct3 values)
  - state enum (IDLE, CALC, FIX, DONE)
  - XLEN default
  - counter width $clog2(XLEN)
- Sub-module muldiv_iter_core:
  - Datapath registers: product/quotient, partial remainder, divisor/multiplicand.
  - One iteration step per enable, plus a sign-fix step.
- The top-level FSM in muldiv_sequencer drives its enables.

## Test plan
- MUL a=7, b=0xFFFF_FFFD (−3) → result 0xFFFF_FFEB; done exactly 34 cycles after start; stall low in the done cycle.
- High multiplies:
  - MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE
  - MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF
- Divides:
  - DIV −7/2 → 0xFFFF_FFFD
  - REM −7/2 → 0xFFFF_FFFF
  - DIVU 100/7 → 14
  - REMU 100/7 → 2
- Short path:
  - DIVU 5/0 → 0xFFFF_FFFF
  - REM 5/0 → 5
  - DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000
  - REM of the same operands → 0
  - Each with done 1 cycle after start.
- Flush:
  - flush at cycle 10 of CALC → busy=0 next cycle, no done, result keeps its old value.
  - A new start next cycle completes normally.
  - flush+start together in IDLE → not accepted.
- Reset and ignored start:
  - rst asserted mid-CALC (asynchronously, between edges) → busy/done/result go to 0 immediately.
  - start asserted while busy is ignored; only the first op's done/result appear.
